// File: rtl/fxp_div_pkg.sv
// Shared types and width helpers for the iterative fixed-point divider.
package fxp_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Wide enough for any saturation limit or magnitude compare we expect to use.
   localparam int SAT_W = 128;

   // Numerator width after aligning the dividend to the quotient/divisor fractions.
   function automatic int num_w(input int a_w, input int a_frac,
                                input int b_frac, input int q_frac);
      return a_w + q_frac + b_frac - a_frac;
   endfunction

   // Number of clock iterations needed to resolve n bits, steps bits at a time.
   function automatic int iters(input int n, input int steps);
      return (n + steps - 1) / steps;
   endfunction

   // Largest positive magnitude of a w-bit signed value (also the 0x7FF..F pattern).
   function automatic logic [SAT_W-1:0] sat_pos(input int w);
      return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
   endfunction

   // Largest negative magnitude of a w-bit signed value (also the 0x800..0 pattern).
   function automatic logic [SAT_W-1:0] sat_neg(input int w);
      return SAT_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring division step: shift in a numerator bit, subtract D if it fits.
module fxp_div_step #(
   parameter int B_W = 16
) (
   input  logic [B_W:0]   r_i,
   input  logic [B_W-1:0] d_i,
   input  logic           n_i,
   output logic [B_W:0]   r_o,
   output logic           q_o
);

   logic [B_W+1:0] sh;
   logic [B_W+1:0] rem;

   // R stays below D after every step, so the shifted value never needs more than B_W+1 bits.
   always_comb begin
      sh  = {r_i, n_i};
      q_o = (sh >= {2'b00, d_i});
      rem = q_o ? (sh - {2'b00, d_i}) : sh;
      r_o = (B_W + 1)'(rem);
   end

endmodule

// File: rtl/fxp_div_iter.sv
// Iterative restoring fixed-point divider: signed dividend, unsigned divisor,
// signed saturating quotient, STEPS quotient bits per clock, valid/ready on both sides.
module fxp_div_iter
   import fxp_div_pkg::*;
#(
   parameter int A_W    = 16,
   parameter int A_FRAC = 14,
   parameter int B_W    = 16,
   parameter int B_FRAC = 14,
   parameter int Q_W    = 16,
   parameter int Q_FRAC = 14,
   parameter int STEPS  = 2,
   parameter int ROUND  = 0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [A_W-1:0] i_a,
   input  logic [B_W-1:0] i_b,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [Q_W-1:0] o_q,
   output logic           o_dz,
   output logic           o_ovf
);

   localparam int SH    = Q_FRAC + B_FRAC - A_FRAC;
   localparam int NUM_W = num_w(A_W, A_FRAC, B_FRAC, Q_FRAC);
   localparam int ITERS = iters(NUM_W, STEPS);
   localparam int NX_W  = ITERS * STEPS;
   localparam int CNT_W = $clog2(ITERS + 1);

   generate
      if (SH < 0) begin : g_bad_frac
         $error("fxp_div_iter: Q_FRAC + B_FRAC must be >= A_FRAC");
      end
      if (!(STEPS == 1 || STEPS == 2 || STEPS == 4)) begin : g_bad_steps
         $error("fxp_div_iter: STEPS must be 1, 2 or 4");
      end
   endgenerate

   state_t            state_q, state_d;
   logic              sign_q, sign_d;
   logic [NX_W-1:0]   n_q, n_d;
   logic [B_W:0]      r_q, r_d;
   logic [B_W-1:0]    d_q, d_d;
   logic [NX_W-1:0]   quot_q, quot_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [Q_W-1:0]    q_q, q_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;

   logic [A_W:0]      a_ext, a_abs;
   logic [B_W:0]      r_ch [STEPS+1];
   logic [STEPS-1:0]  qb;
   logic [NX_W-1:0]   quot_nx;
   logic [NUM_W-1:0]  mag;
   logic              rnd;
   logic [NUM_W:0]    mag_r;
   logic [SAT_W-1:0]  lim;
   logic              ovf_fin;
   logic [Q_W-1:0]    q_fin;

   assign o_ready = i_rst_n && (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign o_q     = q_q;
   assign o_dz    = dz_q;
   assign o_ovf   = ovf_q;

   // Restoring-step chain, consuming numerator bits MSB first.
   assign r_ch[0] = r_q;
   for (genvar g = 0; g < STEPS; g++) begin : g_step
      fxp_div_step #(.B_W(B_W)) u_step (
         .r_i (r_ch[g]),
         .d_i (d_q),
         .n_i (n_q[NX_W-1-g]),
         .r_o (r_ch[g+1]),
         .q_o (qb[STEPS-1-g])
      );
   end

   // Operand magnitude in A_W+1 bits, then the rounded/saturated result of the final step.
   always_comb begin
      a_ext   = {i_a[A_W-1], i_a};
      a_abs   = i_a[A_W-1] ? (~a_ext + 1'b1) : a_ext;
      quot_nx = {quot_q[NX_W-STEPS-1:0], qb};
      // Zero-extension bits at the top of the numerator always yield zero quotient bits.
      mag     = NUM_W'(quot_nx);
      rnd     = (ROUND != 0) && ({r_ch[STEPS], 1'b0} >= {2'b00, d_q});
      mag_r   = {1'b0, mag} + (NUM_W + 1)'(rnd);
      lim     = sign_q ? sat_neg(Q_W) : sat_pos(Q_W);
      ovf_fin = (SAT_W'(mag_r) > lim);
      if (ovf_fin)     q_fin = Q_W'(lim);
      else if (sign_q) q_fin = Q_W'(~mag_r + 1'b1);
      else             q_fin = Q_W'(mag_r);
   end

   // Next-state and datapath update for the IDLE/CALC/DONE sequence.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      n_d     = n_q;
      r_d     = r_q;
      d_d     = d_q;
      quot_d  = quot_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               sign_d = i_a[A_W-1];
               n_d    = NX_W'(a_abs) << SH;
               d_d    = i_b;
               r_d    = '0;
               quot_d = '0;
               cnt_d  = '0;
               ovf_d  = 1'b0;
               if (i_b == '0) begin
                  dz_d    = 1'b1;
                  q_d     = i_a[A_W-1] ? Q_W'(sat_neg(Q_W)) : Q_W'(sat_pos(Q_W));
                  state_d = DONE;
               end else begin
                  dz_d    = 1'b0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            n_d    = n_q << STEPS;
            r_d    = r_ch[STEPS];
            quot_d = quot_nx;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) begin
               q_d     = q_fin;
               ovf_d   = ovf_fin;
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and the registered result, cleared by reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   // Working operands; always reloaded on accept so they need no reset.
   always_ff @(posedge i_clk) begin
      sign_q <= sign_d;
      n_q    <= n_d;
      r_q    <= r_d;
      d_q    <= d_d;
      quot_q <= quot_d;
   end

endmodule

// File: tb/tb_fxp_div_iter.sv
// Directed testbench for fxp_div_iter across several STEPS/ROUND configurations.
module tb_fxp_div_iter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a, b;
   logic        rdy_in;
   logic        iv [4];
   logic        ordy [4];
   logic        ov [4];
   logic [15:0] oq [4];
   logic        odz [4];
   logic        oovf [4];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // u0: STEPS=2 ROUND=0, u1: STEPS=2 ROUND=1, u2: STEPS=1 ROUND=1, u3: STEPS=4 ROUND=0
   fxp_div_iter #(.STEPS(2), .ROUND(0)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[0]), .o_ready(ordy[0]), .i_a(a), .i_b(b),
      .o_valid(ov[0]), .i_ready(rdy_in), .o_q(oq[0]), .o_dz(odz[0]), .o_ovf(oovf[0]));
   fxp_div_iter #(.STEPS(2), .ROUND(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[1]), .o_ready(ordy[1]), .i_a(a), .i_b(b),
      .o_valid(ov[1]), .i_ready(rdy_in), .o_q(oq[1]), .o_dz(odz[1]), .o_ovf(oovf[1]));
   fxp_div_iter #(.STEPS(1), .ROUND(1)) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[2]), .o_ready(ordy[2]), .i_a(a), .i_b(b),
      .o_valid(ov[2]), .i_ready(rdy_in), .o_q(oq[2]), .o_dz(odz[2]), .o_ovf(oovf[2]));
   fxp_div_iter #(.STEPS(4), .ROUND(0)) u3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[3]), .o_ready(ordy[3]), .i_a(a), .i_b(b),
      .o_valid(ov[3]), .i_ready(rdy_in), .o_q(oq[3]), .o_dz(odz[3]), .o_ovf(oovf[3]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Launch one operation on unit u with i_ready held high and check result and latency.
   task automatic run_op(input int u, input logic [15:0] ta, input logic [15:0] tb,
                         input logic [15:0] eq, input logic edz, input logic eovf,
                         input int elat);
      int n;
      @(negedge clk);
      chk($sformatf("u%0d ready_before", u), ordy[u], 1);
      a = ta; b = tb; rdy_in = 1'b1; iv[u] = 1'b1;
      @(negedge clk);
      iv[u] = 1'b0;
      n = 1;
      while (!ov[u] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ov[u]) begin
         chk($sformatf("u%0d timeout a=%h b=%h", u, ta, tb), 0, 1);
      end else begin
         chk($sformatf("u%0d latency a=%h b=%h", u, ta, tb), n, elat);
         chk($sformatf("u%0d q a=%h b=%h", u, ta, tb), oq[u], eq);
         chk($sformatf("u%0d dz a=%h b=%h", u, ta, tb), odz[u], edz);
         chk($sformatf("u%0d ovf a=%h b=%h", u, ta, tb), oovf[u], eovf);
         @(negedge clk);
         chk($sformatf("u%0d valid_after_xfer", u), ov[u], 0);
         chk($sformatf("u%0d ready_after_xfer", u), ordy[u], 1);
      end
   endtask

   initial begin
      int n;
      logic seen;
      rst_n = 1'b0; a = '0; b = '0; rdy_in = 1'b0;
      for (int i = 0; i < 4; i++) iv[i] = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst valid", ov[0], 0);
      chk("rst q", oq[0], 0);
      chk("rst dz", odz[0], 0);
      chk("rst ovf", oovf[0], 0);
      chk("rst ready_low", ordy[0], 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst ready_high", ordy[0], 1);

      // Basic, signed, boundaries, overflow, divide by zero
      run_op(0, 16'h2000, 16'h4000, 16'h2000, 0, 0, 16);
      run_op(0, 16'hC000, 16'h8000, 16'hE000, 0, 0, 16);
      run_op(0, 16'h7FFF, 16'h4000, 16'h7FFF, 0, 0, 16);
      run_op(0, 16'h8000, 16'h4000, 16'h8000, 0, 0, 16);
      run_op(0, 16'h4000, 16'h1000, 16'h7FFF, 0, 1, 16);
      run_op(0, 16'hC000, 16'h1000, 16'h8000, 0, 1, 16);
      run_op(0, 16'h1234, 16'h0000, 16'h7FFF, 1, 0, 1);
      run_op(0, 16'h8000, 16'h0000, 16'h8000, 1, 0, 1);
      run_op(0, 16'h0000, 16'h0000, 16'h7FFF, 1, 0, 1);
      run_op(0, 16'h0000, 16'h4000, 16'h0000, 0, 0, 16);

      // Rounding across configurations
      run_op(0, 16'h0002, 16'h0003, 16'h2AAA, 0, 0, 16);
      run_op(1, 16'h0002, 16'h0003, 16'h2AAB, 0, 0, 16);
      run_op(2, 16'h0002, 16'h0003, 16'h2AAB, 0, 0, 31);
      run_op(3, 16'h0002, 16'h0003, 16'h2AAA, 0, 0, 9);
      run_op(0, 16'hFFFE, 16'h0003, 16'hD556, 0, 0, 16);
      run_op(1, 16'hFFFE, 16'h0003, 16'hD555, 0, 0, 16);
      run_op(3, 16'hC000, 16'h1000, 16'h8000, 0, 1, 9);
      run_op(2, 16'hC000, 16'h8000, 16'hE000, 0, 0, 31);

      // Hold result in DONE with i_ready low; new operands must be ignored
      @(negedge clk);
      a = 16'h2000; b = 16'h4000; rdy_in = 1'b0; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      n = 1;
      while (!ov[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("hold reached_done", ov[0], 1);
      for (int c = 0; c < 5; c++) begin
         a = 16'h4000; b = 16'h1000; iv[0] = 1'b1;
         @(negedge clk);
         chk($sformatf("hold q c%0d", c), oq[0], 16'h2000);
         chk($sformatf("hold ready c%0d", c), ordy[0], 0);
         chk($sformatf("hold valid c%0d", c), ov[0], 1);
      end
      iv[0] = 1'b0; rdy_in = 1'b1;
      @(negedge clk);
      chk("hold valid_drop", ov[0], 0);
      chk("hold ready_rise", ordy[0], 1);

      // Reset during CALC drops the operation
      a = 16'h4000; b = 16'h1000; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst valid", ov[0], 0);
      chk("midrst ready_low", ordy[0], 0);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ov[0]) seen = 1'b1;
      end
      chk("midrst no_result", seen, 0);
      chk("midrst ready_high", ordy[0], 1);
      run_op(0, 16'h2000, 16'h4000, 16'h2000, 0, 0, 16);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
